turbo_ber_monitor: RTL and testbench

TURBO_BER_MONITOR -- requirements
Module: turbo_ber_monitor

---
 rtl/turbo_ber_monitor.sv | 228 ++++++++++++++++++++++
 tb/tb_turbo_ber_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_ber_monitor.sv
// Bit/frame error-rate monitor for a turbo decoder under test.
// Compares each decoded frame against a known pattern (block pattern, all
// zeros or a continuous PRBS-9), and accumulates bit errors, errored frames
// and frame count into one of several independent channels. A run is
// started with a target frame count; the unit drains its two-stage pipeline
// and pulses done once the last frame's counts are visible on the readout.
module turbo_ber_monitor #(
    parameter  int N          = 29,
    parameter  int P          = 3,
    parameter  int CHANNELS   = 4,
    parameter  int CNT_BITS   = 32,
    parameter  int FRAME_BITS = 16,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CW-1:0]         chan_sel,
    input  logic [1:0]            mode,
    input  logic [FRAME_BITS-1:0] frames_target,
    input  logic                  in_valid,
    input  logic                  x [N],
    input  logic [CW-1:0]         rd_chan,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_BITS-1:0]   rd_bit_errors,
    output logic [CNT_BITS-1:0]   rd_frame_errors,
    output logic [FRAME_BITS-1:0] rd_frames
);

    // Width of the per-frame error count, and of the widened saturating sum
    localparam int EW = $clog2(N + 1);
    localparam int SW = ((CNT_BITS > EW) ? CNT_BITS : EW) + 1;

    localparam logic [CNT_BITS-1:0]   CNT_MAX = '1;
    localparam logic [FRAME_BITS-1:0] FRM_MAX = '1;
    localparam logic [8:0]            PRBS_SEED = 9'h1FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Run configuration captured at start
    logic [CW-1:0]         chan_reg;
    logic [1:0]            mode_reg;
    logic [FRAME_BITS-1:0] target_reg;
    logic [FRAME_BITS-1:0] accepted_reg;
    logic [8:0]            prbs_reg;

    // Pattern generation and compare
    logic [N-1:0]  x_bits;
    logic [N-1:0]  block_pat;
    logic [N-1:0]  prbs_pat;
    logic [N-1:0]  expected;
    logic [N-1:0]  diff;
    logic [8:0]    prbs_walk;
    logic [8:0]    prbs_next_frame;
    logic [EW-1:0] errs;

    // Stage 1 pipeline register
    logic          s1_valid_reg;
    logic [EW-1:0] s1_errs_reg;

    logic start_run;
    logic accept;
    logic last_frame;

    // Per-channel counters, flattened so each channel block drives its own slice
    logic [CHANNELS*CNT_BITS-1:0]   bit_err_flat;
    logic [CHANNELS*CNT_BITS-1:0]   frame_err_flat;
    logic [CHANNELS*FRAME_BITS-1:0] frames_flat;

    assign start_run  = (state_reg == S_IDLE) && start;
    // A zero-target run never accepts frames, it only passes through RUN
    assign accept     = (state_reg == S_RUN) && in_valid && (target_reg != '0);
    assign last_frame = accept && (accepted_reg == (target_reg - FRAME_BITS'(1)));

    genvar gi;

    // Flatten the frame and build the constant block pattern: runs of P ones then P zeros
    generate
        for (gi = 0; gi < N; gi++) begin : gen_bits
            assign x_bits[gi]    = x[gi];
            assign block_pat[gi] = (((gi / P) % 2) == 0);
        end
    endgenerate

    // PRBS-9 (x^9 + x^5 + 1): frame bit i is the i-th output bit (state[8]) of the generator
    always_comb begin
        prbs_walk = prbs_reg;
        prbs_pat  = '0;
        for (int i = 0; i < N; i++) begin
            prbs_pat[i] = prbs_walk[8];
            prbs_walk   = {prbs_walk[7:0], prbs_walk[8] ^ prbs_walk[4]};
        end
        prbs_next_frame = prbs_walk;
    end

    // Select the expected frame and count mismatching bits
    always_comb begin
        case (mode_reg)
            2'd1:    expected = '0;
            2'd2:    expected = prbs_pat;
            default: expected = block_pat;
        endcase
        diff = x_bits ^ expected;
        errs = '0;
        for (int i = 0; i < N; i++) begin
            errs = errs + EW'(diff[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if ((target_reg == '0) || last_frame) state_next = S_DRAIN;
            S_DRAIN: if (!s1_valid_reg) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: done fires in the DRAIN cycle after the last frame leaves stage 1
    always_comb begin
        busy = (state_reg == S_RUN) || (state_reg == S_DRAIN);
        done = (state_reg == S_DRAIN) && !s1_valid_reg;
    end

    // Capture run configuration, count accepted frames, advance the PRBS per frame
    always_ff @(posedge clk) begin
        if (reset) begin
            chan_reg     <= '0;
            mode_reg     <= '0;
            target_reg   <= '0;
            accepted_reg <= '0;
            prbs_reg     <= PRBS_SEED;
        end else if (start_run) begin
            chan_reg     <= chan_sel;
            mode_reg     <= mode;
            target_reg   <= frames_target;
            accepted_reg <= '0;
            prbs_reg     <= PRBS_SEED;
        end else if (accept) begin
            accepted_reg <= accepted_reg + FRAME_BITS'(1);
            prbs_reg     <= prbs_next_frame;
        end
    end

    // Stage 1: register the per-frame error count
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_errs_reg  <= '0;
        end else begin
            s1_valid_reg <= accept;
            s1_errs_reg  <= errs;
        end
    end

    // Stage 2: one saturating counter set per channel
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : gen_chan
            logic [CNT_BITS-1:0]   bit_err_reg;
            logic [CNT_BITS-1:0]   frame_err_reg;
            logic [FRAME_BITS-1:0] frames_reg;
            logic [SW-1:0]         bit_sum;
            logic                  hit;

            assign hit     = s1_valid_reg && (chan_reg == CW'(gi));
            assign bit_sum = SW'(bit_err_reg) + SW'(s1_errs_reg);

            // Clear on run start for the selected channel, otherwise accumulate
            always_ff @(posedge clk) begin
                if (reset) begin
                    bit_err_reg   <= '0;
                    frame_err_reg <= '0;
                    frames_reg    <= '0;
                end else if (start_run && (chan_sel == CW'(gi))) begin
                    bit_err_reg   <= '0;
                    frame_err_reg <= '0;
                    frames_reg    <= '0;
                end else if (hit) begin
                    bit_err_reg <= (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_BITS-1:0];
                    if ((s1_errs_reg != '0) && (frame_err_reg != CNT_MAX)) begin
                        frame_err_reg <= frame_err_reg + CNT_BITS'(1);
                    end
                    if (frames_reg != FRM_MAX) begin
                        frames_reg <= frames_reg + FRAME_BITS'(1);
                    end
                end
            end

            assign bit_err_flat[gi*CNT_BITS +: CNT_BITS]       = bit_err_reg;
            assign frame_err_flat[gi*CNT_BITS +: CNT_BITS]     = frame_err_reg;
            assign frames_flat[gi*FRAME_BITS +: FRAME_BITS]    = frames_reg;
        end
    endgenerate

    // Readout mux; unpopulated channel numbers read as zero
    always_comb begin
        rd_bit_errors   = '0;
        rd_frame_errors = '0;
        rd_frames       = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_chan == CW'(c)) begin
                rd_bit_errors   = bit_err_flat[c*CNT_BITS +: CNT_BITS];
                rd_frame_errors = frame_err_flat[c*CNT_BITS +: CNT_BITS];
                rd_frames       = frames_flat[c*FRAME_BITS +: FRAME_BITS];
            end
        end
    end

endmodule

// File: tb/tb_turbo_ber_monitor.sv
// Self-checking bench for turbo_ber_monitor: table of measurement runs with a
// per-frame scoreboard, plus hand sequences for saturation, zero target,
// ignored starts, and reset in mid-run.
module tb_turbo_ber_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  chan_sel;
    logic [1:0]  mode;
    logic [15:0] frames_target;
    logic        in_valid;
    logic        x_in [29];
    logic [1:0]  rd_chan;
    logic        busy, done;
    logic [31:0] rd_bit_errors, rd_frame_errors;
    logic [15:0] rd_frames;
    logic        sat_busy, sat_done;
    logic [3:0]  sat_bit_errors, sat_frame_errors;
    logic [15:0] sat_frames;

    turbo_ber_monitor #(.N(29), .P(3), .CHANNELS(4), .CNT_BITS(32), .FRAME_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .chan_sel(chan_sel), .mode(mode),
        .frames_target(frames_target), .in_valid(in_valid), .x(x_in), .rd_chan(rd_chan),
        .busy(busy), .done(done), .rd_bit_errors(rd_bit_errors),
        .rd_frame_errors(rd_frame_errors), .rd_frames(rd_frames)
    );

    turbo_ber_monitor #(.N(29), .P(3), .CHANNELS(4), .CNT_BITS(4), .FRAME_BITS(16)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .chan_sel(chan_sel), .mode(mode),
        .frames_target(frames_target), .in_valid(in_valid), .x(x_in), .rd_chan(rd_chan),
        .busy(sat_busy), .done(sat_done), .rd_bit_errors(sat_bit_errors),
        .rd_frame_errors(sat_frame_errors), .rd_frames(sat_frames)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int chan;
        int mode;
        int target;
        int gap;
        int extra;
        int flips [6];
        int exp_bit;
        int exp_frm;
        int exp_frames;
    } vec_t;

    typedef struct {
        int due;
        int bits;
        int frms;
        int frames;
    } sb_t;

    sb_t  sb_q [$];
    int   done_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_stop = 0;
    int   flip_pos [8] = '{0, 5, 11, 17, 23, 28, 2, 14};
    logic [8:0] tb_prbs;
    int   m_bit [4];
    int   m_frm [4];
    int   m_frames [4];
    vec_t vecs [8];
    int   exp_ro [4][3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int ch, int md, int tg, int gp, int ex,
                                int f0, int f1, int f2, int f3, int f4, int f5,
                                int eb, int ef, int en);
        vec_t v;
        v.chan = ch; v.mode = md; v.target = tg; v.gap = gp; v.extra = ex;
        v.flips[0] = f0; v.flips[1] = f1; v.flips[2] = f2;
        v.flips[3] = f3; v.flips[4] = f4; v.flips[5] = f5;
        v.exp_bit = eb; v.exp_frm = ef; v.exp_frames = en;
        return v;
    endfunction

    // Build the reference frame for a mode, flip nflip known bits, drive it
    task automatic drive_frame(input int md, input int nflip);
        logic [28:0] f;
        logic        fb;
        for (int i = 0; i < 29; i++) begin
            if (md == 1) begin
                f[i] = 1'b0;
            end else if (md == 2) begin
                f[i]    = tb_prbs[8];
                fb      = tb_prbs[8] ^ tb_prbs[4];
                tb_prbs = {tb_prbs[7:0], fb};
            end else begin
                f[i] = (((i / 3) % 2) == 0);
            end
        end
        for (int k = 0; k < nflip; k++) f[flip_pos[k]] = ~f[flip_pos[k]];
        for (int i = 0; i < 29; i++) x_in[i] = f[i];
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        sb_t e;
        step();
        if (v.extra != 0) begin
            drive_frame(0, 5);          // IDLE: must be ignored
            step();
            in_valid = 1'b0;
        end
        start         = 1'b1;
        chan_sel      = 2'(v.chan);
        mode          = 2'(v.mode);
        frames_target = 16'(v.target);
        rd_chan       = 2'(v.chan);
        m_bit[v.chan] = 0; m_frm[v.chan] = 0; m_frames[v.chan] = 0;
        tb_prbs       = 9'h1FF;
        if (v.target == 0) done_q.push_back(cyc + 2);
        step();
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'(1));
        for (int f = 0; f < v.target; f++) begin
            repeat (v.gap) step();
            drive_frame(v.mode, v.flips[f]);
            m_bit[v.chan] += v.flips[f];
            if (v.flips[f] != 0) m_frm[v.chan]++;
            m_frames[v.chan]++;
            e.due = cyc + 2; e.bits = m_bit[v.chan]; e.frms = m_frm[v.chan]; e.frames = m_frames[v.chan];
            sb_q.push_back(e);
            if (f == v.target - 1) done_q.push_back(cyc + 2);
            step();
            in_valid = 1'b0;
        end
        if (v.extra != 0) begin
            drive_frame(0, 5);          // DRAIN: must be ignored
            step();
            in_valid = 1'b0;
        end
        repeat (3) step();
        check({tag, "_bit_errors"},   64'(rd_bit_errors),   64'(v.exp_bit));
        check({tag, "_frame_errors"}, 64'(rd_frame_errors), 64'(v.exp_frm));
        check({tag, "_frames"},       64'(rd_frames),       64'(v.exp_frames));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; chan_sel = '0; mode = '0; frames_target = '0;
        in_valid = 1'b0; rd_chan = '0;
        for (int i = 0; i < 29; i++) x_in[i] = 1'b0;

        //         ch md tg gp ex  flips per frame        bit frm frames
        vecs[0] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 1);
        vecs[1] = mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0,     2, 1, 1);
        vecs[2] = mk(2, 0, 4, 0, 0, 0, 0, 3, 0, 0, 0,     3, 1, 4);
        vecs[3] = mk(1, 1, 3, 1, 0, 1, 0, 2, 0, 0, 0,     3, 2, 3);
        vecs[4] = mk(3, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 5);
        vecs[5] = mk(1, 3, 2, 2, 0, 4, 1, 0, 0, 0, 0,     5, 2, 2);
        vecs[6] = mk(3, 2, 3, 0, 0, 0, 6, 0, 0, 0, 0,     6, 1, 3);
        vecs[7] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,     0, 0, 1);
        exp_ro[0] = '{2, 1, 1};
        exp_ro[1] = '{0, 0, 1};
        exp_ro[2] = '{3, 1, 4};
        exp_ro[3] = '{6, 1, 3};

        fork
            begin : stimulus
                repeat (3) step();
                reset = 1'b0;
                check("reset_busy", 64'(busy), 64'(0));
                check("reset_done", 64'(done), 64'(0));
                check("reset_bit_errors", 64'(rd_bit_errors), 64'(0));
                check("reset_frames", 64'(rd_frames), 64'(0));

                for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

                // Each channel keeps the result of the last run into it
                for (int ch = 0; ch < 4; ch++) begin
                    rd_chan = 2'(ch);
                    #1;
                    check($sformatf("readout%0d_bit", ch),   64'(rd_bit_errors),   64'(exp_ro[ch][0]));
                    check($sformatf("readout%0d_frm", ch),   64'(rd_frame_errors), 64'(exp_ro[ch][1]));
                    check($sformatf("readout%0d_frames", ch), 64'(rd_frames),      64'(exp_ro[ch][2]));
                end

                // Saturation on the 4-bit-counter instance: 6 frames x 3 errors
                run_vec(mk(0, 0, 6, 0, 0, 3, 3, 3, 3, 3, 3, 18, 6, 6), "sat_wide");
                check("sat_bit_errors",   64'(sat_bit_errors),   64'(15));
                check("sat_frame_errors", 64'(sat_frame_errors), 64'(6));
                check("sat_frames",       64'(sat_frames),       64'(6));

                // Zero target on chan 3, second start while busy must be ignored
                step();
                start = 1'b1; chan_sel = 2'd3; frames_target = 16'd0; mode = 2'd0; rd_chan = 2'd3;
                done_q.push_back(cyc + 2);
                step();
                chan_sel = 2'd1;                // still start=1, RUN now
                step();
                start = 1'b0;
                repeat (3) step();
                check("zero_target_bit",    64'(rd_bit_errors),   64'(0));
                check("zero_target_frames", 64'(rd_frames),       64'(0));
                rd_chan = 2'd1;
                #1;
                check("ignored_start_chan1_frames", 64'(rd_frames), 64'(1));

                // Reset after 2 of 4 frames: frame 1 counted, then everything cleared
                step();
                start = 1'b1; chan_sel = 2'd2; mode = 2'd0; frames_target = 16'd4; rd_chan = 2'd2;
                step();
                start = 1'b0;
                drive_frame(0, 3);
                step();
                drive_frame(0, 1);
                step();
                in_valid = 1'b0;
                check("midrun_frame1_bits", 64'(rd_bit_errors), 64'(3));
                reset = 1'b1;
                step();
                reset = 1'b0;
                check("midrun_reset_busy", 64'(busy), 64'(0));
                for (int ch = 0; ch < 4; ch++) begin
                    rd_chan = 2'(ch);
                    #1;
                    check($sformatf("midrun_reset_ch%0d", ch),
                          64'({rd_bit_errors, rd_frame_errors} | 64'(rd_frames)), 64'(0));
                end
                repeat (4) step();

                // Reset wins over a simultaneous start
                reset = 1'b1; start = 1'b1; chan_sel = 2'd1; frames_target = 16'd2;
                step();
                reset = 1'b0; start = 1'b0;
                check("reset_priority_busy", 64'(busy), 64'(0));
                repeat (3) step();
                mon_stop = 1'b1;
            end
            begin : monitor
                sb_t e;
                bit  exp_done;
                while (!mon_stop) begin
                    @(negedge clk);
                    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                        e = sb_q.pop_front();
                        check($sformatf("frame_bits@%0d", cyc),   64'(rd_bit_errors),   64'(e.bits));
                        check($sformatf("frame_frms@%0d", cyc),   64'(rd_frame_errors), 64'(e.frms));
                        check($sformatf("frame_count@%0d", cyc),  64'(rd_frames),       64'(e.frames));
                    end
                    exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
                    if (exp_done || done !== 1'b0) begin
                        if (exp_done) void'(done_q.pop_front());
                        check($sformatf("done@%0d", cyc), 64'(done), 64'(exp_done));
                    end
                end
            end
        join

        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        check("done_queue_drained", 64'(done_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
